// File: rtl/cpu_pkg.sv
// Shared core definitions: controller state encoding and reset constants
// used by the fetch stage and its neighbours.
package cpu_pkg;

  localparam int unsigned PcWidth = 32;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  localparam logic [31:0]        NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [PcWidth-1:0] RESET_PC_DEFAULT  = '0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one word request per FETCH visit, latches the
// returned instruction for decode and owns the PC register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PcWidth-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0]        NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2:0]         state_i,
  input  logic               pc_update_i,
  input  logic               branch_taken_i,
  input  logic [PcWidth-1:0] branch_target_i,
  output logic               imem_req_o,
  output logic [PcWidth-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        instr_raw_o,
  output logic [PcWidth-1:0] pc_o,
  output logic               fetch_done_o,
  output logic               misaligned_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} fetch_fsm_t;

  fetch_fsm_t         fsm_q, fsm_d;
  logic [PcWidth-1:0] pc_q, pc_d;
  logic [PcWidth-1:0] addr_q, addr_d;
  logic [31:0]        instr_q, instr_d;
  logic               done_q, done_d;
  logic               fetched_q, fetched_d;
  logic               pend_valid_q, pend_valid_d;
  logic [PcWidth-1:0] pend_pc_q, pend_pc_d;
  logic               misaligned_q, misaligned_d;

  logic [PcWidth-1:0] pc_next;
  logic               commit;
  logic [PcWidth-1:0] commit_pc;

  assign pc_next = branch_taken_i ? branch_target_i : pc_q + 32'd4;

  always_comb begin
    fsm_d        = fsm_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    done_d       = 1'b0;
    fetched_d    = fetched_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    misaligned_d = misaligned_q;
    commit       = 1'b0;
    commit_pc    = pc_q;

    if (state_i != ST_FETCH) fetched_d = 1'b0;

    unique case (fsm_q)
      StIdle: begin
        // PC changes take priority so a request never goes out with a stale address.
        if (pc_update_i) begin
          commit       = 1'b1;
          commit_pc    = pc_next;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          commit       = 1'b1;
          commit_pc    = pend_pc_q;
          pend_valid_d = 1'b0;
        end else if (state_i == ST_FETCH && !fetched_q && !misaligned_q) begin
          fsm_d  = StReq;
          addr_d = pc_q;
        end
      end
      StReq: begin
        if (imem_gnt_i) fsm_d = StWait;
      end
      StWait: begin
        if (imem_rvalid_i) begin
          instr_d   = imem_rdata_i;
          done_d    = 1'b1;
          fetched_d = 1'b1;
          fsm_d     = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase

    // In-flight fetch keeps the old address; the newest update wins.
    if (fsm_q != StIdle && pc_update_i) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = pc_next;
    end

    if (commit) begin
      pc_d = commit_pc;
      if (commit_pc[1:0] != 2'b00) misaligned_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q        <= StIdle;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      instr_q      <= NOP_INSTR;
      done_q       <= 1'b0;
      fetched_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      done_q       <= done_d;
      fetched_q    <= fetched_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req_o   = (fsm_q == StReq);
  assign imem_addr_o  = addr_q;
  assign instr_raw_o  = instr_q;
  assign pc_o         = pc_q;
  assign fetch_done_o = done_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, PC commit paths, misalignment
// lockout and asynchronous reset during an outstanding fetch.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        pc_update;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_raw;
  logic [31:0] pc;
  logic        fetch_done;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int req_cnt  = 0;
  logic req_prev = 1'b0;

  fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .state_i        (state),
    .pc_update_i    (pc_update),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_gnt_i     (imem_gnt),
    .imem_rvalid_i  (imem_rvalid),
    .imem_rdata_i   (imem_rdata),
    .instr_raw_o    (instr_raw),
    .pc_o           (pc),
    .fetch_done_o   (fetch_done),
    .misaligned_o   (misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fetch_done) done_cnt <= done_cnt + 1;
    if (imem_req && !req_prev) req_cnt <= req_cnt + 1;
    req_prev <= imem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder: waits for a request, grants after gnt_delay cycles,
  // returns data rv_delay cycles after the grant cycle's successor.
  task automatic serve(input int gnt_delay, input int rv_delay, input logic inject,
                       input logic [31:0] inj_target, input logic [31:0] d,
                       output logic [31:0] addr, output logic stable, output logic done,
                       output logic ok);
    int w = 0;
    ok = 1'b1; stable = 1'b1; done = 1'b0; addr = '0;
    while (!imem_req && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!imem_req) begin
      ok = 1'b0;
      return;
    end
    addr = imem_addr;
    repeat (gnt_delay) begin
      @(negedge clk);
      if (!imem_req || imem_addr !== addr) stable = 1'b0;
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    if (imem_req) stable = 1'b0;
    for (int i = 0; i < rv_delay; i++) begin
      if (inject && i == 0) begin
        pc_update = 1'b1; branch_taken = 1'b1; branch_target = inj_target;
      end
      @(negedge clk);
      pc_update = 1'b0;
    end
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    @(negedge clk);
    imem_rvalid = 1'b0;
    done = fetch_done;
  endtask

  task automatic commit(input logic bt, input logic [31:0] tgt);
    pc_update = 1'b1; branch_taken = bt; branch_target = tgt;
    @(negedge clk);
    pc_update = 1'b0; branch_taken = 1'b0;
  endtask

  int base_done, base_req;

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (instr_raw !== Nop) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr_raw, Nop); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", fetch_done); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", misaligned); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_fetch();
    logic [31:0] a; logic st, dn, ok;
    base_done = done_cnt; base_req = req_cnt;
    state = 3'd0;
    serve(1, 0, 1'b0, 32'h0, 32'h0050_0093, a, st, dn, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_req_seen got=%b exp=1", ok); end
    checks++; if (a !== 32'h0) begin failures++; $display("FAIL basic_addr got=%h exp=%h", a, 32'h0); end
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", dn); end
    checks++; if (instr_raw !== 32'h0050_0093) begin failures++; $display("FAIL basic_instr got=%h exp=%h", instr_raw, 32'h0050_0093); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL basic_pc got=%h exp=0", pc); end
  endtask

  task automatic test_no_refetch();
    repeat (10) @(negedge clk);
    checks++; if (req_cnt - base_req !== 1) begin failures++; $display("FAIL norefetch_reqs got=%0d exp=1", req_cnt - base_req); end
    checks++; if (done_cnt - base_done !== 1) begin failures++; $display("FAIL norefetch_dones got=%0d exp=1", done_cnt - base_done); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL norefetch_req_low got=%b exp=0", imem_req); end
    state = 3'd1;
    @(negedge clk);
  endtask

  task automatic test_pc_update();
    logic [31:0] a; logic st, dn, ok;
    state = 3'd4;
    commit(1'b1, 32'h100);
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL pcupd_branch100 got=%h exp=%h", pc, 32'h100); end
    commit(1'b0, 32'hDEAD_0000);
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL pcupd_seq got=%h exp=%h", pc, 32'h104); end
    commit(1'b1, 32'h40);
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL pcupd_branch40 got=%h exp=%h", pc, 32'h40); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL pcupd_mis got=%b exp=0", misaligned); end
    state = 3'd0;
    serve(0, 0, 1'b0, 32'h0, 32'h00A0_0113, a, st, dn, ok);
    checks++; if (a !== 32'h40 || ok !== 1'b1) begin failures++; $display("FAIL pcupd_fetch_addr got=%h exp=%h", a, 32'h40); end
    checks++; if (instr_raw !== 32'h00A0_0113) begin failures++; $display("FAIL pcupd_instr got=%h exp=%h", instr_raw, 32'h00A0_0113); end
    state = 3'd1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a; logic st, dn, ok;
    state = 3'd0;
    serve(4, 1, 1'b1, 32'h200, 32'h0000_0517, a, st, dn, ok);
    checks++; if (a !== 32'h40 || ok !== 1'b1) begin failures++; $display("FAIL slow_addr got=%h exp=%h", a, 32'h40); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL slow_stable got=%b exp=1", st); end
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL slow_done got=%b exp=1", dn); end
    checks++; if (instr_raw !== 32'h0000_0517) begin failures++; $display("FAIL slow_instr got=%h exp=%h", instr_raw, 32'h0000_0517); end
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL slow_pc_old got=%h exp=%h", pc, 32'h40); end
    @(negedge clk);
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL slow_pc_pending got=%h exp=%h", pc, 32'h200); end
    state = 3'd1;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    state = 3'd4;
    commit(1'b1, 32'h102);
    checks++; if (pc !== 32'h102) begin failures++; $display("FAIL mis_pc got=%h exp=%h", pc, 32'h102); end
    checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", misaligned); end
    base_req = req_cnt;
    state = 3'd0;
    repeat (8) @(negedge clk);
    checks++; if (req_cnt - base_req !== 0) begin failures++; $display("FAIL mis_no_req got=%0d exp=0", req_cnt - base_req); end
    state = 3'd4;
    commit(1'b1, 32'hFFFF_FFFC);
    commit(1'b0, 32'h0);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_sticky got=%b exp=1", misaligned); end
    state = 3'd1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    state = 3'd0;
    while (!imem_req && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rstmid_req_seen got=%b exp=1", imem_req); end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    base_done = done_cnt;
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req_drop got=%b exp=0", imem_req); end
    checks++; if (instr_raw !== Nop) begin failures++; $display("FAIL rstmid_instr got=%h exp=%h", instr_raw, Nop); end
    @(negedge clk);
    rst = 1'b0;
    state = 3'd1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (done_cnt - base_done !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt - base_done); end
    checks++; if (instr_raw !== Nop) begin failures++; $display("FAIL rstmid_stale got=%h exp=%h", instr_raw, Nop); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", imem_req); end
  endtask

  initial begin
    rst = 1'b1; state = 3'd1; pc_update = 1'b0; branch_taken = 1'b0;
    branch_target = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_no_refetch();
    test_pc_update();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the multi-cycle core, directly upstream of decode. During the FETCH controller state it requests one 32-bit word from instruction memory at the current PC. It latches the returned word as instr_raw, which decode consumes in the DECODE state. It also owns the PC register and applies the next-PC (sequential or branch/jump target) when the WRITE state completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset.
NOP_INSTR, 32'h0000_0013, instr_raw value after reset (addi x0,x0,0).

Ports:
clk  in  1  core clock.
rst  in  1  asynchronous, active-high reset.
state  in  3  controller state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4.
pc_update  in  1  one-cycle pulse in WRITE: commit the next PC.
branch_taken  in  1  qualifies pc_update; 1 selects branch_target.
branch_target  in  32  absolute target computed by exec.
imem_req  out  1  request valid.
imem_addr  out  32  word address; equals pc while imem_req=1.
imem_gnt  in  1  memory accepted the request this cycle.
imem_rvalid  in  1  read data valid.
imem_rdata  in  32  read data.
instr_raw  out  32  latched instruction for decode.
pc  out  32  PC of the instruction held in instr_raw.
fetch_done  out  1  one-cycle pulse: instr_raw updated; controller may leave FETCH.
misaligned  out  1  sticky; set when a committed PC has bits [1:0] != 0.

Behaviour:
Reset (asynchronous, active-high):
- pc=RESET_PC, instr_raw=NOP_INSTR, imem_req=0, imem_addr=RESET_PC, fetch_done=0, misaligned=0.
- FSM=IDLE, fetched flag=0, pending-update register cleared.

FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ: state==FETCH and fetched==0 and misaligned==0.
  - imem_req and imem_addr=pc are registered, so the request appears the cycle after the condition is sampled.
- REQ: imem_req=1 and imem_addr held stable until imem_gnt=1 is sampled.
  - On gnt: imem_req drops next cycle, FSM -> WAIT.
- WAIT: on imem_rvalid, instr_raw<=imem_rdata, fetch_done=1 for exactly one cycle, fetched<=1, FSM -> IDLE.
  - rvalid arrives no earlier than the cycle after gnt.
- Minimum latency from state==FETCH to fetch_done: 3 cycles (req, gnt, rvalid each one cycle apart).

fetched flag:
- Cleared in any cycle where state != FETCH. This prevents re-fetching while the controller is still in FETCH after fetch_done.

imem_rvalid / imem_gnt outside their states:
- rvalid outside WAIT is ignored, including stale responses after a reset.
- gnt outside REQ is ignored.

PC commit on pc_update:
- next = branch_taken ? branch_target : pc+32'd4 (32-bit wrap: 32'hFFFF_FFFC+4 = 0).
- Accepted in IDLE: pc<=next one cycle later.
- If pc_update arrives in REQ or WAIT: next is held in the pending register; the in-flight fetch completes with the old address; pc<=pending the cycle after return to IDLE.
- A second pc_update while one is pending overwrites the pending value.

misaligned:
- Set when a committed pc has [1:0] != 0. The pc is still updated.
- No further requests are issued until reset. instr_raw holds its last value.

Reset mid-transaction: imem_req drops immediately (asynchronous); no fetch_done is produced.

Decomposition:
- Shared package cpu_pkg: state encoding constants (ST_FETCH..ST_WRITE), NOP_INSTR, RESET_PC default, PC width.
- fetch_fsm_t enum (IDLE/REQ/WAIT) is local to fetch_unit.
- No sub-module is warranted: one FSM plus the PC and pending registers.

Test Plan:
- Reset then state=0, memory returns gnt after 1 cycle and rvalid 2 cycles later with rdata=32'h00500093 -> imem_addr=0, one fetch_done pulse, instr_raw=32'h00500093, pc=0.
- Hold state=0 for 10 cycles after fetch_done -> exactly one request and one fetch_done.
- pc_update with branch_taken=0 in IDLE at pc=0x100 -> pc=0x104; repeat with branch_taken=1, target=0x40 -> pc=0x40, next fetch addr 0x40.
- Delay gnt 4 cycles -> imem_addr stable throughout, imem_req high until gnt; inject pc_update (target 0x200) during WAIT -> in-flight fetch delivered, then pc=0x200.
- branch_target=0x102 committed -> misaligned=1, no further imem_req while state=0; pc=0xFFFFFFFC sequential update -> pc=0.
- Assert rst while in WAIT, then rvalid next cycle -> imem_req=0 immediately, instr_raw=NOP_INSTR, no fetch_done.
